multicycle_ctrl: RTL

Multicycle control unit for the RISC-V core. It sequences one shared ALU, register file, immediate extender and unified instruction/data memory through fetch, decode, execute, memory and writeback states. It drives all datapath selects, including `IMMsrc` for the extender, from the opcode latched in the instruction register. It also handshakes every memory access with a `mem_ready` response.

---
 rtl/multicycle_ctrl.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
`timescale 1ns/1ps
// Multicycle RISC-V control unit: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and unified memory, handshaking each access with mem_ready.
module multicycle_ctrl #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] instr,
  input  logic         Zero,
  input  logic         mem_ready,
  output logic         mem_req,
  output logic         MemWrite,
  output logic         AdrSrc,
  output logic         IRWrite,
  output logic         PCWrite,
  output logic         RegWrite,
  output logic [1:0]   ALUSrcA,
  output logic [1:0]   ALUSrcB,
  output logic [1:0]   ResultSrc,
  output logic [2:0]   ALUControl,
  output logic [2:0]   IMMsrc,
  output logic         illegal_instr
);

  typedef enum logic [3:0] {
    ST_RESET,
    ST_FETCH,
    ST_DECODE,
    ST_MEMADR,
    ST_MEMREAD,
    ST_MEMWB,
    ST_MEMWRITE,
    ST_EXECR,
    ST_EXECI,
    ST_ALUWB,
    ST_BRANCH,
    ST_JAL,
    ST_LUI
  } state_t;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_R      = 7'b0110011,
    OP_IMM    = 7'b0010011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_LUI    = 7'b0110111
  } opcode_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101
  } alu_t;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100
  } imm_t;

  state_t     state, state_next;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic [2:0] imm_sel;
  logic       unused_instr_bits;

  assign op       = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7b5 = instr[30];
  assign unused_instr_bits = &{1'b0, instr[W-1:31], instr[29:15], instr[11:7]};

  function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub_sel);
    logic [2:0] fn;
    case (f3)
      3'b000:  fn = sub_sel ? ALU_SUB : ALU_ADD;
      3'b010:  fn = ALU_SLT;
      3'b100:  fn = ALU_XOR;
      3'b110:  fn = ALU_OR;
      3'b111:  fn = ALU_AND;
      default: fn = ALU_ADD;
    endcase
    return fn;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RESET;
    else        state <= state_next;
  end

  always_comb begin
    imm_sel = IMM_I;
    case (op)
      OP_STORE:  imm_sel = IMM_S;
      OP_BRANCH: imm_sel = IMM_B;
      OP_LUI:    imm_sel = IMM_U;
      OP_JAL:    imm_sel = IMM_J;
      default:   imm_sel = IMM_I;
    endcase
  end

  // IR contents are stale until the fetch completes, so the extender select is held at 0 there.
  assign IMMsrc = (state == ST_RESET || state == ST_FETCH) ? '0 : imm_sel;

  always_comb begin
    state_next    = state;
    mem_req       = 1'b0;
    MemWrite      = 1'b0;
    AdrSrc        = 1'b0;
    IRWrite       = 1'b0;
    PCWrite       = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    ResultSrc     = 2'b00;
    ALUControl    = ALU_ADD;
    illegal_instr = 1'b0;

    case (state)
      ST_RESET: state_next = ST_FETCH;

      ST_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) state_next = ST_DECODE;
      end

      ST_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_next = ST_MEMADR;
          OP_R:              state_next = ST_EXECR;
          OP_IMM:            state_next = ST_EXECI;
          OP_BRANCH:         state_next = ST_BRANCH;
          OP_JAL:            state_next = ST_JAL;
          OP_LUI:            state_next = ST_LUI;
          default: begin
            illegal_instr = 1'b1;
            state_next    = ST_FETCH;
          end
        endcase
      end

      ST_MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        state_next = (op == OP_STORE) ? ST_MEMWRITE : ST_MEMREAD;
      end

      ST_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) state_next = ST_MEMWB;
      end

      ST_MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        state_next = ST_FETCH;
      end

      ST_MEMWRITE: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        if (mem_ready) state_next = ST_FETCH;
      end

      ST_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b00;
        ALUControl = alu_decode(funct3, funct7b5);
        state_next = ST_ALUWB;
      end

      ST_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_decode(funct3, 1'b0);
        state_next = ST_ALUWB;
      end

      ST_ALUWB: begin
        ResultSrc  = 2'b00;
        RegWrite   = 1'b1;
        state_next = ST_FETCH;
      end

      ST_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_SUB;
        PCWrite    = ((funct3 == 3'b000) && Zero) || ((funct3 == 3'b001) && !Zero);
        state_next = ST_FETCH;
      end

      ST_JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        PCWrite    = 1'b1;
        state_next = ST_ALUWB;
      end

      ST_LUI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        state_next = ST_ALUWB;
      end

      default: state_next = ST_RESET;
    endcase
  end

endmodule
